// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries the execute result to the memory stage and
// keeps the madd/msub partial product and step count while execute is stalled.
module ex_mem_reg #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned EX_IDX  = 3,
    parameter int unsigned MEM_IDX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [4:0]         ex_dest_addr,
    input  logic               ex_wreg,
    input  logic [31:0]        ex_dest_data,
    input  logic [31:0]        ex_hi,
    input  logic [31:0]        ex_lo,
    input  logic               ex_whilo,
    input  logic [63:0]        ex_hilo_temp,
    input  logic [1:0]         ex_cnt,
    output logic [4:0]         mem_dest_addr,
    output logic               mem_wreg,
    output logic [31:0]        mem_dest_data,
    output logic [31:0]        mem_hi,
    output logic [31:0]        mem_lo,
    output logic               mem_whilo,
    output logic [63:0]        hilo_temp_out,
    output logic [1:0]         cnt_out
);

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned HLW = 64;
    localparam int unsigned CW  = 2;

    logic [AW-1:0]  dest_addr_q, dest_addr_d;
    logic           wreg_q, wreg_d;
    logic [DW-1:0]  dest_data_q, dest_data_d;
    logic [DW-1:0]  hi_q, hi_d;
    logic [DW-1:0]  lo_q, lo_d;
    logic           whilo_q, whilo_d;
    logic [HLW-1:0] hilo_temp_q, hilo_temp_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic stall_ex, stall_mem;
    logic unused_stall;

    assign stall_ex     = stall[EX_IDX];
    assign stall_mem    = stall[MEM_IDX];
    assign unused_stall = ^stall;

    // Action select: flush, then advance (illegal ex=0/mem=1 lands here), bubble, else hold.
    always_comb begin
        dest_addr_d = dest_addr_q;
        wreg_d      = wreg_q;
        dest_data_d = dest_data_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        whilo_d     = whilo_q;
        hilo_temp_d = hilo_temp_q;
        cnt_d       = cnt_q;
        if (flush) begin
            dest_addr_d = '0;
            wreg_d      = 1'b0;
            dest_data_d = '0;
            hi_d        = '0;
            lo_d        = '0;
            whilo_d     = 1'b0;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else if (!stall_ex) begin
            dest_addr_d = ex_dest_addr;
            wreg_d      = ex_wreg;
            dest_data_d = ex_dest_data;
            hi_d        = ex_hi;
            lo_d        = ex_lo;
            whilo_d     = ex_whilo;
            hilo_temp_d = '0;
            cnt_d       = '0;
        end else if (!stall_mem) begin
            dest_addr_d = '0;
            wreg_d      = 1'b0;
            dest_data_d = '0;
            hi_d        = '0;
            lo_d        = '0;
            whilo_d     = 1'b0;
            hilo_temp_d = ex_hilo_temp;
            cnt_d       = ex_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dest_addr_q <= '0;
            wreg_q      <= 1'b0;
            dest_data_q <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            whilo_q     <= 1'b0;
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else begin
            dest_addr_q <= dest_addr_d;
            wreg_q      <= wreg_d;
            dest_data_q <= dest_data_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            whilo_q     <= whilo_d;
            hilo_temp_q <= hilo_temp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_dest_addr = dest_addr_q;
    assign mem_wreg      = wreg_q;
    assign mem_dest_data = dest_data_q;
    assign mem_hi        = hi_q;
    assign mem_lo        = lo_q;
    assign mem_whilo     = whilo_q;
    assign hilo_temp_out = hilo_temp_q;
    assign cnt_out       = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed scenarios plus random traffic, all checked
// against a transaction-level model of the stall/flush rules.
module tb_ex_mem_reg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned EX_IDX  = 3;
    localparam int unsigned MEM_IDX = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [4:0]         ex_dest_addr;
    logic               ex_wreg;
    logic [31:0]        ex_dest_data;
    logic [31:0]        ex_hi;
    logic [31:0]        ex_lo;
    logic               ex_whilo;
    logic [63:0]        ex_hilo_temp;
    logic [1:0]         ex_cnt;
    logic [4:0]         mem_dest_addr;
    logic               mem_wreg;
    logic [31:0]        mem_dest_data;
    logic [31:0]        mem_hi;
    logic [31:0]        mem_lo;
    logic               mem_whilo;
    logic [63:0]        hilo_temp_out;
    logic [1:0]         cnt_out;

    ex_mem_reg #(.STALL_W(STALL_W), .EX_IDX(EX_IDX), .MEM_IDX(MEM_IDX)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_dest_addr(ex_dest_addr), .ex_wreg(ex_wreg), .ex_dest_data(ex_dest_data),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
        .mem_dest_addr(mem_dest_addr), .mem_wreg(mem_wreg), .mem_dest_data(mem_dest_data),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_temp_out(hilo_temp_out), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected view of the memory stage and the feedback pair
    typedef struct {
        logic [4:0]  addr;
        logic        wreg;
        logic [31:0] data;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] temp;
        logic [1:0]  cnt;
    } view_t;

    view_t exp_v;
    view_t nop_v;

    always @(posedge clk)
        assert (!(!stall[EX_IDX] && stall[MEM_IDX]))
            else $error("FAIL illegal_stall got=%b", stall);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  64'(mem_dest_addr), 64'(exp_v.addr));
        check({tag, ".wreg"},  64'(mem_wreg),      64'(exp_v.wreg));
        check({tag, ".data"},  64'(mem_dest_data), 64'(exp_v.data));
        check({tag, ".hi"},    64'(mem_hi),        64'(exp_v.hi));
        check({tag, ".lo"},    64'(mem_lo),        64'(exp_v.lo));
        check({tag, ".whilo"}, 64'(mem_whilo),     64'(exp_v.whilo));
        check({tag, ".temp"},  hilo_temp_out,      exp_v.temp);
        check({tag, ".cnt"},   64'(cnt_out),       64'(exp_v.cnt));
    endtask

    // One clock edge: choose the action the rules dictate, then compare.
    task automatic tick(input string tag);
        view_t ex_v;
        @(posedge clk);
        ex_v = '{ex_dest_addr, ex_wreg, ex_dest_data, ex_hi, ex_lo, ex_whilo, 64'd0, 2'd0};
        if (rst || flush) begin
            exp_v = nop_v;
        end else if (stall[EX_IDX] && stall[MEM_IDX]) begin
            exp_v = exp_v;
        end else if (stall[EX_IDX]) begin
            exp_v      = nop_v;
            exp_v.temp = ex_hilo_temp;
            exp_v.cnt  = ex_cnt;
        end else begin
            exp_v = ex_v;
        end
        #1;
        check_all(tag);
    endtask

    task automatic rand_ex();
        ex_dest_addr = 5'($urandom);
        ex_wreg      = 1'($urandom);
        ex_dest_data = $urandom;
        ex_hi        = $urandom;
        ex_lo        = $urandom;
        ex_whilo     = 1'($urandom);
        ex_hilo_temp = {$urandom, $urandom};
        ex_cnt       = 2'($urandom);
    endtask

    logic [31:0] held_data;
    logic [63:0] held_temp;
    logic [31:0] b2b [3];

    initial begin
        nop_v = '{5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'd0, 2'd0};
        exp_v = nop_v;
        stall = '0;
        flush = 1'b0;

        // Reset with busy inputs, held for two edges
        ex_dest_addr = 5'd31; ex_wreg = 1'b1; ex_dest_data = 32'hDEAD_BEEF;
        ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222; ex_whilo = 1'b1;
        ex_hilo_temp = 64'hFFFF_0000_FFFF_0000; ex_cnt = 2'b11;
        rst = 1'b1;
        tick("reset0");
        tick("reset1");
        check("reset_cnt", 64'(cnt_out), 64'd0);
        rst = 1'b0;

        // Advance
        ex_dest_addr = 5'd7; ex_wreg = 1'b1; ex_dest_data = 32'h1234_5678;
        ex_whilo = 1'b1; ex_hi = 32'hA; ex_lo = 32'hB;
        tick("adv");
        check("adv_data", 64'(mem_dest_data), 64'h1234_5678);
        check("adv_addr", 64'(mem_dest_addr), 64'd7);

        // madd: bubble carries partial product, then final advance
        stall = 6'b001111; ex_cnt = 2'b01; ex_hilo_temp = 64'h0000_0001_FFFF_FFFE;
        tick("madd1");
        check("madd1_cnt",  64'(cnt_out), 64'd1);
        check("madd1_temp", hilo_temp_out, 64'h0000_0001_FFFF_FFFE);
        check("madd1_wreg", 64'(mem_wreg), 64'd0);
        stall = '0; ex_cnt = 2'b10; ex_hi = 32'h0000_0001; ex_lo = 32'hFFFF_FFFE;
        tick("madd2");
        check("madd2_cnt", 64'(cnt_out), 64'd0);
        check("madd2_lo",  64'(mem_lo),  64'hFFFF_FFFE);

        // Hold for three cycles while inputs churn
        stall = 6'b001111; ex_cnt = 2'b01; ex_hilo_temp = 64'h55AA_55AA_0F0F_0F0F;
        tick("hold_pre_bubble");
        ex_dest_data = 32'hCAFE_F00D; stall = '0;
        tick("hold_load");
        stall = 6'b001111; ex_cnt = 2'b10; ex_hilo_temp = 64'h0123_4567_89AB_CDEF;
        tick("hold_bubble");
        held_data = mem_dest_data;
        held_temp = hilo_temp_out;
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            rand_ex();
            tick("hold");
            check("hold_temp", hilo_temp_out, held_temp);
            check("hold_data", 64'(mem_dest_data), 64'(held_data));
        end

        // Flush beats stall mid-madd
        stall = 6'b001111; ex_cnt = 2'b01; ex_hilo_temp = 64'h0000_0001_FFFF_FFFE;
        tick("flush_pre");
        check("flush_pre_cnt", 64'(cnt_out), 64'd1);
        flush = 1'b1; rand_ex();
        tick("flush");
        check("flush_cnt", 64'(cnt_out), 64'd0);
        flush = 1'b0; stall = '0;

        // Back-to-back advances
        for (int i = 0; i < 3; i++) begin
            b2b[i] = $urandom;
            rand_ex();
            ex_dest_data = b2b[i];
            tick("b2b");
            check("b2b_data", 64'(mem_dest_data), 64'(b2b[i]));
        end

        // Random traffic with legal stall encodings
        for (int i = 0; i < 400; i++) begin
            rand_ex();
            stall = STALL_W'($urandom);
            if (!stall[EX_IDX]) stall[MEM_IDX] = 1'b0;
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 31) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
